regwrite_trace_buffer: RTL and testbench
========================================

// Module: regwrite_trace_buffer
// PURPOSE
// - Parametrised successor to the processor harness's per-cycle register-bank dump.
// - Captures every register write-back event {pc, reg index, data} from the processor into a circular buffer.
// - Supports a PC trigger that freezes the buffer after a programmable number of post-trigger writes.
// - Drains entries through a valid/ready port, either to a bench or to an on-chip debug link.
// PARAMETERS
// - DATA_W    32  width of write-back data and of the PC field
// - IDX_W     5   register index width (32 registers)
// - DEPTH     16  buffer entries; power of two, >= 2
// - WRAP      1   1: overwrite oldest entry when full; 0: drop new entries when full
// - POST_W    8   width of the post_cnt input
// PORTS
// - clk       in   1                clock, rising edge
// - rst       in   1                asynchronous, active-low reset
// - clear     in   1                synchronous flush of pointers, count, overflow and FSM
// - cap_en    in   1                capture enable (arms the FSM)
// - wb_valid  in   1                write-back strobe (RegWrite)
// - wb_pc     in   DATA_W           PC of the writing instruction
// - wb_idx    in   IDX_W            destination register
// - wb_data   in   DATA_W           value written
// - trig_en   in   1                enables the PC trigger
// - trig_pc   in   DATA_W           trigger address
// - post_cnt  in   POST_W           writes captured after the trigger before freezing
// - rd_valid  out  1                head entry available
// - rd_ready  in   1                consumer accepts the head entry
// - rd_pc / rd_idx / rd_data  out  DATA_W/IDX_W/DATA_W  head entry (show-ahead)
// - count     out  $clog2(DEPTH)+1  occupied entries
// - overflow  out  1                sticky; set on any drop or overwrite
// - frozen    out  1                FSM is in FROZEN
// BEHAVIOUR
// - Reset: all outputs 0, FSM in IDLE, pointers 0. Storage contents are don't-care.
// - Event: wb_valid && wb_idx != 0 (writes to $zero are never captured).
// - FSM states: IDLE, RUN, POST, FROZEN.
//   - IDLE->RUN when cap_en=1.
//   - RUN->IDLE when cap_en=0.
//   - RUN->POST on an event with trig_en && wb_pc==trig_pc. The trigger event itself is captured; remaining is loaded with post_cnt.
//   - POST decrements remaining on each captured event; at 0 goes to FROZEN.
//   - If post_cnt==0, the FSM goes RUN->FROZEN directly.
//   - FROZEN holds until clear. Capture runs in RUN and POST only. cap_en=0 in POST still completes the post count.
// - Capture is stored at the clock edge; the entry appears on rd_* one cycle after the event.
// - Pop happens when rd_valid && rd_ready; rd_ptr advances at that edge. rd_valid = (count != 0).
// - rd_* must be stable while rd_valid=1 and rd_ready=0, unless WRAP=1 overwrites the head.
// - Full, WRAP=1: the new entry overwrites the oldest; both pointers advance; count stays at DEPTH; overflow is set.
// - Full, WRAP=0: the new entry is dropped, overflow is set, and count is unchanged.
// - Full, with a simultaneous capture and pop:
//   - The pop takes effect first, then the write; no overflow.
//   - count is unchanged; the popped entry is the one presented before the edge.
// - Empty, with a simultaneous capture and pop: the pop is ignored (rd_valid=0).
// - Pointers wrap modulo DEPTH.
// - clear beats capture and pop in the same cycle.
// - Async reset mid-drain discards all entries immediately.
// CONFIGURATION
// - TRACE_TIMESTAMP_EN defined:
//   - A free-running 32-bit cycle counter (reset 0, counts every clk) is stored with each entry.
//   - It is presented on an extra output rd_ts [31:0], which is 0 at reset.
// - TRACE_TIMESTAMP_EN undefined: no counter, no rd_ts port; all other behaviour is identical.
// STRUCTURE
// - Shared package trace_pkg.vh holds:
//   - FSM state encodings TR_IDLE=2'd0, TR_RUN=2'd1, TR_POST=2'd2, TR_FROZEN=2'd3;
//   - the entry field widths and the entry packing order {ts, pc, idx, data}.
// - One sub-module, trace_ram:
//   - simple dual-port DEPTH x entry-width array with one synchronous write port;
//   - asynchronous read at rd_ptr for show-ahead.
// - Pointers, count, overflow and the FSM stay in the top module.
// TESTING
// - 5 events (idx 1..5, data 0xA1..0xA5), rd_ready=0 -> count=5; draining yields idx 1..5 in order, each one cycle after its event.
// - Event with wb_idx=0 -> nothing captured, count unchanged.
// - WRAP=1, DEPTH=16, 20 events data 1..20 -> overflow=1, count=16; drain yields 5..20.
// - WRAP=0, same stimulus -> drain yields 1..16. Full with a simultaneous event and pop -> count stays 16, overflow stays 0.
// - trig_pc=0x40, post_cnt=3, events at pc 0x30,0x40,0x44,0x48,0x4C,0x50 -> frozen=1 after the 0x4C event; 0x50 not captured.
// - clear asserted with a simultaneous event, then rst low mid-drain -> both give count=0, rd_valid=0, overflow=0, FSM in IDLE.

Source files
------------

// File: rtl/regwrite_trace_buffer_pkg.sv
// Shared types for the register write-back trace buffer.
// Defining TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp to every stored entry.
package regwrite_trace_buffer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPost   = 2'd2,
        StFrozen = 2'd3
    } tr_state_e;

`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned TsW = 32;
`endif

    // Entry layout, MSB first: {ts, pc, idx, data}; ts exists only with timestamps.
    function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned idx_w);
`ifdef TRACE_TIMESTAMP_EN
        return TsW + 2 * data_w + idx_w;
`else
        return 2 * data_w + idx_w;
`endif
    endfunction

endpackage

// File: rtl/regwrite_trace_buffer_if.sv
// Write-back capture bus and show-ahead drain port of the trace buffer.
// With TRACE_TIMESTAMP_EN the drain side also carries rd_ts.
interface regwrite_trace_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 5
);
    logic              wb_valid;
    logic [DATA_W-1:0] wb_pc;
    logic [IDX_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_pc;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]       rd_ts;

    modport master (
        output wb_valid, wb_pc, wb_idx, wb_data, rd_ready,
        input  rd_valid, rd_pc, rd_idx, rd_data, rd_ts
    );
    modport slave (
        input  wb_valid, wb_pc, wb_idx, wb_data, rd_ready,
        output rd_valid, rd_pc, rd_idx, rd_data, rd_ts
    );
`else
    modport master (
        output wb_valid, wb_pc, wb_idx, wb_data, rd_ready,
        input  rd_valid, rd_pc, rd_idx, rd_data
    );
    modport slave (
        input  wb_valid, wb_pc, wb_idx, wb_data, rd_ready,
        output rd_valid, rd_pc, rd_idx, rd_data
    );
`endif

endinterface

// File: rtl/regwrite_trace_buffer_trace_ram.sv
// Trace storage: synchronous write port, asynchronous read port for show-ahead.
module trace_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/regwrite_trace_buffer.sv
// Circular trace of register write-back events with PC trigger and post-trigger freeze.
// TRACE_TIMESTAMP_EN stores a free-running cycle count with each entry.
module regwrite_trace_buffer
    import regwrite_trace_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WRAP   = 1,
    parameter int unsigned POST_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     cap_en,
    regwrite_trace_buffer_if.slave   bus,
    input  logic                     trig_en,
    input  logic [DATA_W-1:0]        trig_pc,
    input  logic [POST_W-1:0]        post_cnt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     frozen
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = entry_w(DATA_W, IDX_W);

    tr_state_e         state_q, state_d;
    logic [POST_W-1:0] rem_q, rem_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;

    logic          wb_event, capture, rd_valid, pop, full, we;
    logic [EW-1:0] wdata, rdata;

    assign wb_event = bus.wb_valid && (bus.wb_idx != '0);
    assign capture  = wb_event && ((state_q == StRun) || (state_q == StPost));
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && bus.rd_ready;
    assign full     = (count_q == CW'(DEPTH));

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        we         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cap_en) state_d = StRun;
            end
            StRun: begin
                // The trigger event is captured in this same cycle.
                if (wb_event && trig_en && (bus.wb_pc == trig_pc)) begin
                    if (post_cnt == '0) begin
                        state_d = StFrozen;
                    end else begin
                        state_d = StPost;
                        rem_d   = post_cnt;
                    end
                end else if (!cap_en) begin
                    state_d = StIdle;
                end
            end
            StPost: begin
                if (capture) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == POST_W'(1)) state_d = StFrozen;
                end
            end
            StFrozen: ;
            default: state_d = StIdle;
        endcase

        if (capture && (!full || pop || (WRAP != 0))) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (capture && full && !pop) overflow_d = 1'b1;

        // An overwrite when full retires the oldest entry just like a pop.
        if (pop || (we && full)) rd_ptr_d = rd_ptr_q + 1'b1;

        if (we && !pop && !full) begin
            count_d = count_q + 1'b1;
        end else if (pop && !we) begin
            count_d = count_q - 1'b1;
        end

        if (clear) begin
            state_d    = StIdle;
            rem_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            we         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TsW-1:0] ts_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign wdata     = {ts_q, bus.wb_pc, bus.wb_idx, bus.wb_data};
    assign bus.rd_ts = rd_valid ? rdata[2*DATA_W+IDX_W +: TsW] : '0;
`else
    assign wdata = {bus.wb_pc, bus.wb_idx, bus.wb_data};
`endif

    trace_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Stale storage is masked so an empty buffer presents all zeros.
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_valid ? rdata[DATA_W-1:0] : '0;
    assign bus.rd_idx   = rd_valid ? rdata[DATA_W +: IDX_W] : '0;
    assign bus.rd_pc    = rd_valid ? rdata[DATA_W+IDX_W +: DATA_W] : '0;

    assign count    = count_q;
    assign overflow = overflow_q;
    assign frozen   = (state_q == StFrozen);

endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// Directed bench: a wrapping and a dropping instance driven in lockstep,
// with per-instance scoreboard queues holding the expected drain order.
module tb_regwrite_trace_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        cap_en = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic [7:0]  post_cnt = '0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [4:0]  wb_idx = '0;
    logic [31:0] wb_data = '0;
    logic        rdy_w = 1'b0;
    logic        rdy_d = 1'b0;
    logic [4:0]  count_w, count_d;
    logic        ovf_w, ovf_d, frz_w, frz_d;

    int   n_cmp = 0;
    int   n_fail = 0;
    ent_t q_w[$];
    ent_t q_d[$];

    always #5 clk = ~clk;

    regwrite_trace_buffer_if #(.DATA_W(32), .IDX_W(5)) bus_w ();
    regwrite_trace_buffer_if #(.DATA_W(32), .IDX_W(5)) bus_d ();

    assign bus_w.wb_valid = wb_valid;
    assign bus_w.wb_pc    = wb_pc;
    assign bus_w.wb_idx   = wb_idx;
    assign bus_w.wb_data  = wb_data;
    assign bus_w.rd_ready = rdy_w;
    assign bus_d.wb_valid = wb_valid;
    assign bus_d.wb_pc    = wb_pc;
    assign bus_d.wb_idx   = wb_idx;
    assign bus_d.wb_data  = wb_data;
    assign bus_d.rd_ready = rdy_d;

    regwrite_trace_buffer #(
        .DATA_W(32), .IDX_W(5), .DEPTH(16), .WRAP(1), .POST_W(8)
    ) u_wrap (
        .clk(clk), .rst(rst), .clear(clear), .cap_en(cap_en), .bus(bus_w),
        .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
        .count(count_w), .overflow(ovf_w), .frozen(frz_w)
    );

    regwrite_trace_buffer #(
        .DATA_W(32), .IDX_W(5), .DEPTH(16), .WRAP(0), .POST_W(8)
    ) u_drop (
        .clk(clk), .rst(rst), .clear(clear), .cap_en(cap_en), .bus(bus_d),
        .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
        .count(count_d), .overflow(ovf_d), .frozen(frz_d)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: wrap instance drops its oldest, drop instance drops the newest.
    task automatic push(input ent_t e);
        if (q_w.size() == 16) q_w.delete(0);
        q_w.push_back(e);
        if (q_d.size() < 16) q_d.push_back(e);
    endtask

    task automatic wb_event(input logic [31:0] pc, input logic [4:0] idx,
                            input logic [31:0] data, input bit cap);
        wb_valid = 1'b1;
        wb_pc    = pc;
        wb_idx   = idx;
        wb_data  = data;
        if (cap && idx != 5'd0) push('{pc: pc, idx: idx, data: data});
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic check_both(input string tag, input int cnt, input bit ovf, input bit frz);
        check({tag, "_count_w"}, count_w, cnt);
        check({tag, "_count_d"}, count_d, cnt);
        check({tag, "_ovf_w"}, ovf_w, ovf);
        check({tag, "_ovf_d"}, ovf_d, ovf);
        check({tag, "_frozen_w"}, frz_w, frz);
        check({tag, "_frozen_d"}, frz_d, frz);
    endtask

    task automatic drain(input bit sel, input string tag);
        ent_t e;
        for (int i = 0; i < 64; i++) begin
            if (sel) begin
                if (q_d.size() == 0) break;
                e = q_d.pop_front();
                check({tag, "_valid_d"}, bus_d.rd_valid, 1'b1);
                check({tag, "_pc_d"}, bus_d.rd_pc, e.pc);
                check({tag, "_idx_d"}, bus_d.rd_idx, e.idx);
                check({tag, "_data_d"}, bus_d.rd_data, e.data);
                rdy_d = 1'b1;
            end else begin
                if (q_w.size() == 0) break;
                e = q_w.pop_front();
                check({tag, "_valid_w"}, bus_w.rd_valid, 1'b1);
                check({tag, "_pc_w"}, bus_w.rd_pc, e.pc);
                check({tag, "_idx_w"}, bus_w.rd_idx, e.idx);
                check({tag, "_data_w"}, bus_w.rd_data, e.data);
                rdy_w = 1'b1;
            end
            @(negedge clk);
            rdy_w = 1'b0;
            rdy_d = 1'b0;
        end
        check({tag, "_empty_count"}, sel ? count_d : count_w, 0);
        check({tag, "_empty_valid"}, sel ? bus_d.rd_valid : bus_w.rd_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pcs [6];
        pcs = '{32'h30, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_both("reset", 0, 1'b0, 1'b0);
        check("reset_valid_w", bus_w.rd_valid, 1'b0);
        check("reset_data_w", bus_w.rd_data, 32'h0);
        check("reset_pc_d", bus_d.rd_pc, 32'h0);
        rst = 1'b1;
        cap_en = 1'b1;
        @(negedge clk);

        // Five events; head appears one cycle after the first
        for (int i = 1; i <= 5; i++) begin
            wb_event(32'h100 + 32'(4 * i), 5'(i), 32'hA0 + 32'(i), 1'b1);
            check("t1_count_w", count_w, i);
            check("t1_head_idx_w", bus_w.rd_idx, 5'd1);
        end
        wb_event(32'h200, 5'd0, 32'hDEAD, 1'b1);
        check_both("t2_zero_idx", 5, 1'b0, 1'b0);
        drain(1'b0, "t1_drain");
        drain(1'b1, "t1_drain");

        // Capture with pop while empty: the pop is ignored
        rdy_w = 1'b1;
        rdy_d = 1'b1;
        wb_event(32'h300, 5'd7, 32'h77, 1'b1);
        rdy_w = 1'b0;
        rdy_d = 1'b0;
        check_both("empty_pop", 1, 1'b0, 1'b0);
        drain(1'b0, "empty_pop_drain");
        drain(1'b1, "empty_pop_drain");

        // Twenty events into sixteen slots
        for (int i = 1; i <= 20; i++) begin
            wb_event(32'h400 + 32'(4 * i), 5'((i % 31) + 1), 32'(i), 1'b1);
        end
        check_both("t3_full", 16, 1'b1, 1'b0);
        drain(1'b0, "t3_wrap");
        drain(1'b1, "t3_drop");
        check("t3_sticky_ovf_w", ovf_w, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_both("t3_clear", 0, 1'b0, 1'b0);
        @(negedge clk);

        // Full with a simultaneous event and pop
        for (int i = 1; i <= 16; i++) begin
            wb_event(32'h500 + 32'(4 * i), 5'(i), 32'h1000 + 32'(i), 1'b1);
        end
        check_both("t4_full", 16, 1'b0, 1'b0);
        check("t4_head_w", bus_w.rd_data, q_w[0].data);
        check("t4_head_d", bus_d.rd_data, q_d[0].data);
        q_w.delete(0);
        q_d.delete(0);
        rdy_w = 1'b1;
        rdy_d = 1'b1;
        wb_event(32'h600, 5'd17, 32'h2000, 1'b1);
        rdy_w = 1'b0;
        rdy_d = 1'b0;
        check_both("t4_full_pop", 16, 1'b0, 1'b0);
        drain(1'b0, "t4_drain");
        drain(1'b1, "t4_drain");

        // PC trigger with three post-trigger writes
        trig_en  = 1'b1;
        trig_pc  = 32'h40;
        post_cnt = 8'd3;
        for (int k = 0; k < 6; k++) begin
            wb_event(pcs[k], 5'(k + 1), 32'h30 + 32'(k), k < 5);
            check("t6_frozen_w", frz_w, k >= 4);
            check("t6_frozen_d", frz_d, k >= 4);
        end
        check_both("t6_end", 5, 1'b0, 1'b1);
        drain(1'b0, "t6_drain");
        drain(1'b1, "t6_drain");
        trig_en = 1'b0;

        // Clear leaves FROZEN; then clear beats a simultaneous event
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t5_unfrozen_w", frz_w, 1'b0);
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            wb_event(32'h700 + 32'(4 * i), 5'(i), 32'h90 + 32'(i), 1'b1);
        end
        check_both("t5_pre_clear", 3, 1'b0, 1'b0);
        clear  = 1'b1;
        cap_en = 1'b0;
        wb_event(32'h720, 5'd9, 32'h99, 1'b0);
        clear = 1'b0;
        q_w.delete();
        q_d.delete();
        check_both("t5_clear", 0, 1'b0, 1'b0);
        check("t5_clear_valid_d", bus_d.rd_valid, 1'b0);
        wb_event(32'h724, 5'd10, 32'hAA, 1'b0);
        check_both("t5_idle", 0, 1'b0, 1'b0);

        // Async reset in the middle of a drain
        cap_en = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 17; i++) begin
            wb_event(32'h800 + 32'(4 * i), 5'(i), 32'h3000 + 32'(i), 1'b1);
        end
        check_both("t7_pre_rst", 16, 1'b1, 1'b0);
        rdy_w = 1'b1;
        rdy_d = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_both("t7_rst", 0, 1'b0, 1'b0);
        check("t7_rst_valid_w", bus_w.rd_valid, 1'b0);
        check("t7_rst_valid_d", bus_d.rd_valid, 1'b0);
        q_w.delete();
        q_d.delete();
        rdy_w  = 1'b0;
        rdy_d  = 1'b0;
        cap_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wb_event(32'h900, 5'd4, 32'h44, 1'b0);
        check_both("t7_idle", 0, 1'b0, 1'b0);

        // post_cnt of zero freezes on the trigger event itself
        cap_en = 1'b1;
        @(negedge clk);
        trig_en  = 1'b1;
        trig_pc  = 32'h40;
        post_cnt = 8'd0;
        wb_event(32'h40, 5'd3, 32'h33, 1'b1);
        check_both("t8_trig0", 1, 1'b0, 1'b1);
        wb_event(32'h44, 5'd4, 32'h44, 1'b0);
        check_both("t8_hold", 1, 1'b0, 1'b1);
        drain(1'b0, "t8_drain");
        drain(1'b1, "t8_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
